// File: rtl/tiger_key_sched.sv
// Tiger message-word sequencer and key-schedule engine.
// Loads one 512-bit block, streams the eight x words per pass as
// (x, mul, rnd, last) tuples over a valid/ready handshake, and runs the
// two-cycle Tiger key schedule (KS1, KS2) between passes.
// Optional feature macro: TIGER_PASS4_EN adds a fourth pass (rnd 24..31).
module tiger_key_sched (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_blk_vld,
  output logic         o_blk_rdy,
  input  logic [511:0] i_blk,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [63:0]  o_x,
  output logic [3:0]   o_mul,
  output logic [4:0]   o_rnd,
  output logic         o_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    KS1  = 2'd2,
    KS2  = 2'd3
  } state_t;

`ifdef TIGER_PASS4_EN
  localparam logic [1:0] LAST_PASS = 2'd3;
`else
  localparam logic [1:0] LAST_PASS = 2'd2;
`endif

  localparam logic [63:0] KS_C1 = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] KS_C2 = 64'h0123456789ABCDEF;

  state_t            state_q;
  logic [2:0]        idx_q;
  logic [1:0]        pass_q;
  logic [7:0][63:0]  x_q;
  logic              hs;

  // Schedule steps 1-8; each step consumes the result of the previous one.
  function automatic logic [7:0][63:0] ks_first(input logic [7:0][63:0] x);
    logic [7:0][63:0] t;
    t    = x;
    t[0] = t[0] - (t[7] ^ KS_C1);
    t[1] = t[1] ^ t[0];
    t[2] = t[2] + t[1];
    t[3] = t[3] - (t[2] ^ ((~t[1]) << 19));
    t[4] = t[4] ^ t[3];
    t[5] = t[5] + t[4];
    t[6] = t[6] - (t[5] ^ ((~t[4]) >> 23));
    t[7] = t[7] ^ t[6];
    return t;
  endfunction

  // Schedule steps 9-16; each step consumes the result of the previous one.
  function automatic logic [7:0][63:0] ks_second(input logic [7:0][63:0] x);
    logic [7:0][63:0] t;
    t    = x;
    t[0] = t[0] + t[7];
    t[1] = t[1] - (t[0] ^ ((~t[7]) << 19));
    t[2] = t[2] ^ t[1];
    t[3] = t[3] + t[2];
    t[4] = t[4] - (t[3] ^ ((~t[2]) >> 23));
    t[5] = t[5] ^ t[4];
    t[6] = t[6] + t[5];
    t[7] = t[7] - (t[6] ^ KS_C2);
    return t;
  endfunction

  assign hs = (state_q == PASS) && i_rdy;

  // Control FSM: state, word index and pass counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      pass_q  <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_blk_vld) begin
            idx_q   <= 3'd0;
            pass_q  <= 2'd0;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (hs) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= (pass_q == LAST_PASS) ? IDLE : KS1;
            end
          end
        end
        KS1: begin
          state_q <= KS2;
        end
        KS2: begin
          pass_q  <= pass_q + 2'd1;
          idx_q   <= 3'd0;
          state_q <= PASS;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Word register file: block load in IDLE, key schedule in KS1/KS2.
  // No reset: contents are always overwritten by a block load before use.
  always_ff @(posedge i_clk) begin
    case (state_q)
      IDLE:    if (i_blk_vld) x_q <= i_blk;
      KS1:     x_q <= ks_first(x_q);
      KS2:     x_q <= ks_second(x_q);
      default: ;
    endcase
  end

  // Pass multiplier; the final pass(es) beyond pass 1 all use 9.
  always_comb begin
    o_mul = 4'd0;
    if (state_q == PASS) begin
      case (pass_q)
        2'd0:    o_mul = 4'd5;
        2'd1:    o_mul = 4'd7;
        default: o_mul = 4'd9;
      endcase
    end
  end

  // Outputs decode registered state only, so they stay stable during stalls
  // and read as zero whenever no word is being offered.
  assign o_blk_rdy = (state_q == IDLE);
  assign o_vld     = (state_q == PASS);
  assign o_x       = o_vld ? x_q[idx_q] : 64'd0;
  assign o_rnd     = o_vld ? {pass_q, idx_q} : 5'd0;
  assign o_last    = o_vld && (pass_q == LAST_PASS) && (idx_q == 3'd7);

endmodule
